// File: rtl/cmd_aggregator_pkg.sv
// Shared command-word definitions used by the UART command aggregator and the
// command dispatcher: frame length and the 24-bit command layout.
package cmd_aggregator_pkg;

    // Number of UART bytes making up one command frame.
    localparam int unsigned CMD_BYTES = 3;

    // Width of the assembled command word.
    localparam int unsigned CMD_W = CMD_BYTES * 8;

    // Command word as seen by the dispatcher. The first byte on the wire
    // lands in the most significant field.
    typedef struct packed {
        logic [7:0] opcode;  // pad/opcode byte (byte0)
        logic [7:0] arg_hi;  // byte1
        logic [7:0] arg_lo;  // byte2
    } cmd_t;

    // Shift one received byte into the low end of the command word; older
    // bytes move toward the opcode field so byte0 ends up on top.
    function automatic cmd_t cmd_shift_in(input cmd_t cur, input logic [7:0] b);
        cmd_t nxt;
        nxt.opcode = cur.arg_hi;
        nxt.arg_hi = cur.arg_lo;
        nxt.arg_lo = b;
        return nxt;
    endfunction

endpackage

// File: rtl/cmd_aggregator.sv
// UART command aggregator: collects three bytes (MSB first) into a 24-bit
// command, holds it for the dispatcher until acknowledged, and drops partial
// frames when the gap between bytes of one frame grows too long.
//
// Handshakes:
//   UART side: rx_rdy is a level that means "rx_data holds a byte". The byte
//   is consumed in the cycle clr_rx_rdy is high (combinational, same cycle as
//   the acceptance); the UART drops rx_rdy the following cycle. While a full
//   command is held no byte is consumed, so rx_rdy simply stays high.
//   Dispatcher side: cmd is valid while cmd_rdy is high; cmd_rdy stays high
//   until the dispatcher raises clr_cmd_rdy for a cycle. clr_cmd_rdy while no
//   command is held has no effect.
//
// state_dbg exposes the FSM: 0=WAIT_B0, 1=WAIT_B1, 2=WAIT_B2, 3=FULL.
module cmd_aggregator
    import cmd_aggregator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_rdy,
    output logic             clr_rx_rdy,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    output logic             frame_err,
    output logic [1:0]       state_dbg
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    // Counter value in the last idle cycle before the frame is abandoned:
    // the increment out of this value would make it reach TIMEOUT_CYC.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        FULL    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    cmd_t             cmd_q;
    logic             cmd_rdy_q;
    logic             frame_err_q;
    logic             byte_take;

    // Decide whether the pending UART byte is consumed this cycle.
    always_comb begin
        byte_take = 1'b0;
        case (state)
            WAIT_B0, WAIT_B1, WAIT_B2: byte_take = rx_rdy;
            default:                   byte_take = 1'b0;
        endcase
    end

    // The consume strobe is held low while reset is asserted so the UART
    // never sees a byte taken by a block that is being cleared.
    assign clr_rx_rdy = byte_take & rst_n;

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frame_err = frame_err_q;
    assign state_dbg = state;

    // Frame assembly FSM with inter-byte timeout and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_B0;
            tmo_cnt     <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state)
                WAIT_B0: begin
                    // No timeout while waiting for the first byte of a frame.
                    tmo_cnt <= '0;
                    if (rx_rdy) begin
                        cmd_q <= cmd_shift_in(cmd_q, rx_data);
                        state <= WAIT_B1;
                    end
                end

                WAIT_B1: begin
                    if (rx_rdy) begin
                        // A byte arriving in the timeout cycle still counts.
                        cmd_q   <= cmd_shift_in(cmd_q, rx_data);
                        tmo_cnt <= '0;
                        state   <= WAIT_B2;
                    end else if (tmo_cnt == CNT_LAST) begin
                        tmo_cnt     <= '0;
                        frame_err_q <= 1'b1;
                        state       <= WAIT_B0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                WAIT_B2: begin
                    if (rx_rdy) begin
                        cmd_q     <= cmd_shift_in(cmd_q, rx_data);
                        tmo_cnt   <= '0;
                        cmd_rdy_q <= 1'b1;
                        state     <= FULL;
                    end else if (tmo_cnt == CNT_LAST) begin
                        tmo_cnt     <= '0;
                        frame_err_q <= 1'b1;
                        state       <= WAIT_B0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                FULL: begin
                    // Command frozen; any waiting byte is left for WAIT_B0,
                    // so it is never consumed in the acknowledge cycle.
                    tmo_cnt <= '0;
                    if (clr_cmd_rdy) begin
                        cmd_rdy_q <= 1'b0;
                        state     <= WAIT_B0;
                    end
                end

                default: begin
                    tmo_cnt   <= '0;
                    cmd_rdy_q <= 1'b0;
                    state     <= WAIT_B0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_aggregator.sv
// Directed bench for cmd_aggregator with a short timeout. Driver tasks feed
// UART bytes and dispatcher acknowledges; a monitor compares every new
// command and every frame_err pulse against queued expectations.
module tb_cmd_aggregator;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        frame_err;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int clr_cnt = 0;
    int last_acc_cyc = 0;

    logic [23:0] exp_q[$];
    int          err_q[$];
    logic        prev_rdy = 1'b0;

    cmd_aggregator #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .frame_err   (frame_err),
        .state_dbg   (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drivers: every task starts and ends 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        int n = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        while (!got && n < 64) begin
            @(negedge clk);
            if (clr_rx_rdy === 1'b1) got = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        rx_rdy = 1'b0;
        last_acc_cyc = cyc;
        check("byte_accepted", {31'd0, got}, 32'd1);
    endtask

    task automatic ack_cmd();
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 64) begin
            @(negedge clk);
            if (cmd_rdy === 1'b1) seen = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check("cmd_rdy_seen", {31'd0, seen}, 32'd1);
        clr_cmd_rdy = 1'b1;
        idle(1);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check("cmd_rdy_cleared", {31'd0, cmd_rdy}, 32'd0);
        idle(1);
    endtask

    // Monitor: scores each new command and each frame_err pulse.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_rdy <= 1'b0;
        end else begin
            if (clr_rx_rdy === 1'b1) clr_cnt <= clr_cnt + 1;
            if (cmd_rdy === 1'b1 && !prev_rdy) begin
                if (exp_q.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
                else check("cmd_value", {8'd0, cmd}, {8'd0, exp_q.pop_front()});
            end
            if (frame_err === 1'b1) begin
                if (err_q.size() == 0) check("frame_err_unexpected", 32'd1, 32'd0);
                else check("frame_err_cycle", cyc, err_q.pop_front());
            end
            prev_rdy <= cmd_rdy;
        end
    end

    initial begin
        int c0;
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = 1'b0;
        idle(2);
        @(negedge clk);
        check("rst_cmd", {8'd0, cmd}, 32'h0);
        check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        rx_rdy = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // 1: three bytes with gaps, command one cycle after the last byte.
        exp_q.push_back(24'h020C00);
        c0 = clr_cnt;
        send_byte(8'h02); idle(3);
        send_byte(8'h0C); idle(3);
        send_byte(8'h00);
        @(negedge clk);
        check("t1_latency", {31'd0, cmd_rdy}, 32'd1);
        check("t1_clr_pulses", clr_cnt - c0, 32'd3);
        idle(1);

        // 2: held command back-pressures a fourth byte.
        exp_q.push_back(24'h050607);
        rx_data = 8'h05;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("t2_no_take", {31'd0, clr_rx_rdy}, 32'd0);
            check("t2_cmd_frozen", {8'd0, cmd}, 32'h020C00);
            idle(1);
        end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        check("t2_no_take_in_clear", {31'd0, clr_rx_rdy}, 32'd0);
        idle(1);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check("t2_rdy_dropped", {31'd0, cmd_rdy}, 32'd0);
        check("t2_take_after_clear", {31'd0, clr_rx_rdy}, 32'd1);
        idle(1);
        rx_rdy = 1'b0;
        send_byte(8'h06);
        send_byte(8'h07);
        ack_cmd();
        idle(30);

        // 3: partial frame abandoned after TMO idle cycles.
        send_byte(8'h09);
        err_q.push_back(last_acc_cyc + TMO);
        idle(TMO + 4);
        @(negedge clk);
        check("t3_state_b0", {30'd0, state_dbg}, 32'd0);
        check("t3_err_seen", err_q.size(), 32'd0);
        idle(1);
        exp_q.push_back(24'h010000);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        ack_cmd();

        // 4: byte in the exact timeout cycle wins.
        exp_q.push_back(24'h112233);
        send_byte(8'h11);
        idle(TMO - 1);
        send_byte(8'h22);
        idle(TMO - 1);
        send_byte(8'h33);
        ack_cmd();

        // 5: reset in the middle of a frame.
        send_byte(8'h44);
        send_byte(8'h55);
        rst_n = 1'b0;
        #2;
        check("t5_cmd_cleared", {8'd0, cmd}, 32'h0);
        check("t5_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("t5_state", {30'd0, state_dbg}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(1);
        exp_q.push_back(24'h0805A5);
        send_byte(8'h08);
        send_byte(8'h05);
        send_byte(8'hA5);
        ack_cmd();

        // 6: acknowledge outside FULL is ignored.
        exp_q.push_back(24'h0A0B0C);
        send_byte(8'h0A);
        clr_cmd_rdy = 1'b1;
        idle(1);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check("t6_state_b1", {30'd0, state_dbg}, 32'd1);
        idle(1);
        send_byte(8'h0B);
        send_byte(8'h0C);
        ack_cmd();

        idle(5);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("err_q_drained", err_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
